pipeline_hazard_ctrl: RTL and testbench
=======================================

# pipeline_hazard_ctrl

Central pipeline controller for the 5-stage CPU. It generates the write-enable and flush controls for the PC and the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, taken branches/jumps, variable-latency memory waits and halt, and keeps a stall performance counter. It sits beside the decoder. It takes control bits already latched into EX and produces the `flush` input of the ID/EX register.

## Interface

Parameters:
- `REG_ADDR_W`, default 3: register-specifier width.
- `MEM_TIMEOUT`, default 255: maximum MEMWAIT cycles before the access is aborted. Legal range is 2..255.

Ports:
- `clock` input 1: sole clock; all state updates on posedge.
- `reset_n` input 1: asynchronous, active-low reset.
- `id_src_a`, `id_src_b` input REG_ADDR_W: source registers of the instruction in ID.
- `id_use_a`, `id_use_b` input 1: ID instruction actually reads src_a / src_b.
- `ex_dest` input REG_ADDR_W: destination register of the instruction in EX.
- `ex_memRead`, `ex_regWrite`, `ex_halt` input 1: EX-stage control bits.
- `ex_branch_taken`, `ex_jump` input 1: redirect resolved in EX.
- `mem_req` input 1: MEM stage has an access in flight.
- `mem_ready` input 1: memory completes the access this cycle.
- `pc_write_en`, `if_id_write_en`, `id_ex_write_en`, `ex_mem_write_en` output 1: pipeline-register enables.
- `if_id_flush`, `id_ex_flush` output 1: load a bubble (all zero) into IF/ID and ID/EX.
- `halted` output 1: registered; core is halted.
- `mem_error` output 1: registered, sticky; a memory access timed out.
- `stall_count` output 16: registered, saturating count of stall cycles.

## Operation

- FSM states: RUN, MEMWAIT, HALT. All enable and flush outputs are Mealy-combinational from the state and inputs.
- Default in RUN is all enables 1 and both flushes 0.
- RUN priority is fixed and evaluated top-down:
  1. `ex_halt`: PC/IF-ID enables 0; `if_id_flush`=1, `id_ex_flush`=1; `ex_mem_write_en`=1. Next state HALT.
  2. `mem_req && !mem_ready`: all four enables 0; flushes 0. Next state MEMWAIT; `wait_cnt` cleared.
  3. `ex_branch_taken || ex_jump`: enables 1; `if_id_flush`=1, `id_ex_flush`=1. PC loads the target.
  4. Load-use: `ex_memRead && ex_regWrite && ((id_use_a && id_src_a==ex_dest) || (id_use_b && id_src_b==ex_dest))`. Then `pc_write_en`=0, `if_id_write_en`=0, `id_ex_flush`=1, `id_ex_write_en`=1, `ex_mem_write_en`=1. This is exactly one bubble; the hazard clears on its own the next cycle.
- MEMWAIT:
  - All enables 0, flushes 0, and `wait_cnt` increments each cycle.
  - `mem_ready`=1 in MEMWAIT: outputs follow RUN priorities 1, 3, 4 (rule 2 is ignored); next state RUN.
  - Timeout cycle is `wait_cnt==MEM_TIMEOUT-1` with `!mem_ready`. Outputs follow RUN priorities 1, 3, 4 (access aborted); `mem_error` is set; next state RUN.
- HALT:
  - All enables 0, flushes 0, `halted`=1.
  - All inputs are ignored; only `reset_n` exits HALT.
- `stall_count` increments when `pc_write_en`=0 in RUN or MEMWAIT, except for the halt-entry cycle. It saturates at 16'hFFFF and never wraps.
- Branch and load-use in the same cycle: branch wins. No stall occurs and the count is unchanged.

## Timing

- While `reset_n`=0, regardless of clock:
  - State is RUN; `wait_cnt`=0; `stall_count`=0; `halted`=0; `mem_error`=0.
  - All enables are forced 0 and both flushes forced 1, so bubbles flush the reset-less pipeline registers.
- Reset asserted mid-MEMWAIT or in HALT: takes effect immediately, with no pending state retained.
- On the first posedge after `reset_n` rises, normal RUN behaviour applies. Outputs are combinational the same cycle.
- Load-use costs exactly 1 cycle. A branch costs 2 squashed instructions with 0 stall cycles.
- `halted` rises on the posedge that ends the halt-entry cycle.
- `mem_error` rises on the posedge ending the timeout cycle.
- `stall_count` updates on the posedge ending each stall cycle.
- Stall-cycle totals:
  - A memory wait with `mem_ready` arriving N cycles after the request stalls N cycles.
  - A timeout stalls exactly MEM_TIMEOUT cycles.

## Test plan

- Reset pulse of 3 cycles during MEMWAIT with `stall_count`=5 -> enables immediately 0, flushes 1. After release: state RUN, `stall_count`=0, `mem_error`=0.
- `ex_memRead`=1, `ex_regWrite`=1, `ex_dest`=3, `id_use_a`=1, `id_src_a`=3 for one cycle -> `pc_write_en`=0, `if_id_write_en`=0, `id_ex_flush`=1 for 1 cycle; `stall_count` goes 0->1. The same stimulus with `id_use_a`=0 gives no stall.
- Load-use condition plus `ex_branch_taken`=1 together -> `pc_write_en`=1, both flushes 1, `stall_count` unchanged.
- `mem_req`=1 with `mem_ready`=0 for 4 cycles, then 1 -> enables 0 for 4 cycles, back to RUN, `stall_count` +4, `mem_error`=0.
- MEM_TIMEOUT=8 with `mem_ready` stuck 0 -> 8 stall cycles; the 9th cycle has enables 1; `mem_error`=1 thereafter until reset.
- `ex_halt`=1, then `ex_branch_taken`=1 and `mem_req`=1 for 10 cycles -> `halted`=1 after the first edge, all enables 0, flushes 0, `stall_count` frozen. Only `reset_n` recovers.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central hazard/stall controller for the 5-stage core. It produces the write
// enables for PC, IF/ID, ID/EX and EX/MEM, and the bubble (flush) controls for
// IF/ID and ID/EX. It resolves halt, variable-latency memory waits (with
// timeout), taken branches/jumps and load-use hazards, and keeps a saturating
// count of stall cycles.
//
// Ports
//   clock, reset_n            : clock, asynchronous active-low reset
//   id_src_a/b, id_use_a/b    : source registers of the ID instruction and whether they are read
//   ex_dest, ex_memRead,
//   ex_regWrite, ex_halt      : control bits of the instruction in EX
//   ex_branch_taken, ex_jump  : redirect resolved in EX
//   mem_req, mem_ready        : MEM access in flight / completing this cycle
//   *_write_en, *_flush       : combinational pipeline-register controls
//   halted, mem_error         : registered status (mem_error is sticky)
//   stall_count               : registered saturating stall-cycle counter
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W  = 3,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [REG_ADDR_W-1:0] id_src_a,
    input  logic [REG_ADDR_W-1:0] id_src_b,
    input  logic                  id_use_a,
    input  logic                  id_use_b,
    input  logic [REG_ADDR_W-1:0] ex_dest,
    input  logic                  ex_memRead,
    input  logic                  ex_regWrite,
    input  logic                  ex_halt,
    input  logic                  ex_branch_taken,
    input  logic                  ex_jump,
    input  logic                  mem_req,
    input  logic                  mem_ready,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  id_ex_write_en,
    output logic                  ex_mem_write_en,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  halted,
    output logic                  mem_error,
    output logic [15:0]           stall_count
);

    localparam int unsigned WAIT_W  = 8;
    localparam int unsigned STALL_W = 16;

    // Last MEMWAIT cycle before the access is abandoned.
    localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = '1;

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_MEMWAIT = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WAIT_W-1:0]    r_wait_cnt;
    logic [STALL_W-1:0]   r_stall_count;
    logic                 r_halted;
    logic                 r_mem_error;

    logic                 w_redirect;
    logic                 w_load_use;

    // Outcome of the halt / redirect / load-use priority chain.
    logic                 w_res_pc_we;
    logic                 w_res_if_id_we;
    logic                 w_res_id_ex_we;
    logic                 w_res_ex_mem_we;
    logic                 w_res_if_id_fl;
    logic                 w_res_id_ex_fl;

    // FSM-selected controls before the reset override.
    logic                 w_pc_we;
    logic                 w_if_id_we;
    logic                 w_id_ex_we;
    logic                 w_ex_mem_we;
    logic                 w_if_id_fl;
    logic                 w_id_ex_fl;

    logic                 w_wait_clr;
    logic                 w_wait_inc;
    logic                 w_timeout;
    logic                 w_halt_entry;
    logic                 w_stall;

    // Hazard detection on the EX-latched control bits.
    assign w_redirect = ex_branch_taken | ex_jump;
    assign w_load_use = ex_memRead & ex_regWrite &
                        ((id_use_a & (id_src_a == ex_dest)) |
                         (id_use_b & (id_src_b == ex_dest)));

    // Halt > redirect > load-use; shared by RUN and by the MEMWAIT exit cycle.
    always_comb begin
        w_res_pc_we     = 1'b1;
        w_res_if_id_we  = 1'b1;
        w_res_id_ex_we  = 1'b1;
        w_res_ex_mem_we = 1'b1;
        w_res_if_id_fl  = 1'b0;
        w_res_id_ex_fl  = 1'b0;
        if (ex_halt) begin
            w_res_pc_we    = 1'b0;
            w_res_if_id_we = 1'b0;
            w_res_if_id_fl = 1'b1;
            w_res_id_ex_fl = 1'b1;
        end else if (w_redirect) begin
            // Squash the two younger instructions; PC loads the target.
            w_res_if_id_fl = 1'b1;
            w_res_id_ex_fl = 1'b1;
        end else if (w_load_use) begin
            // Hold PC and IF/ID, insert one bubble into ID/EX.
            w_res_pc_we    = 1'b0;
            w_res_if_id_we = 1'b0;
            w_res_id_ex_fl = 1'b1;
        end
    end

    // State register and status registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_RUN;
            r_wait_cnt    <= '0;
            r_stall_count <= '0;
            r_halted      <= 1'b0;
            r_mem_error   <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_halted <= (w_next_state == S_HALT);
            if (w_wait_clr) begin
                r_wait_cnt <= '0;
            end else if (w_wait_inc) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_timeout) begin
                r_mem_error <= 1'b1;
            end
            if (w_stall && (r_stall_count != STALL_MAX)) begin
                r_stall_count <= r_stall_count + STALL_W'(1);
            end
        end
    end

    // Next-state and control selection.
    always_comb begin
        w_next_state = r_state;
        w_pc_we      = 1'b0;
        w_if_id_we   = 1'b0;
        w_id_ex_we   = 1'b0;
        w_ex_mem_we  = 1'b0;
        w_if_id_fl   = 1'b0;
        w_id_ex_fl   = 1'b0;
        w_wait_clr   = 1'b0;
        w_wait_inc   = 1'b0;
        w_timeout    = 1'b0;
        w_halt_entry = 1'b0;

        case (r_state)
            S_RUN: begin
                if (!ex_halt && mem_req && !mem_ready) begin
                    // Freeze the whole pipe until memory answers.
                    w_next_state = S_MEMWAIT;
                    w_wait_clr   = 1'b1;
                end else begin
                    w_pc_we     = w_res_pc_we;
                    w_if_id_we  = w_res_if_id_we;
                    w_id_ex_we  = w_res_id_ex_we;
                    w_ex_mem_we = w_res_ex_mem_we;
                    w_if_id_fl  = w_res_if_id_fl;
                    w_id_ex_fl  = w_res_id_ex_fl;
                    if (ex_halt) begin
                        w_next_state = S_HALT;
                        w_halt_entry = 1'b1;
                    end
                end
            end

            S_MEMWAIT: begin
                if (mem_ready || (r_wait_cnt == WAIT_LAST)) begin
                    // Completion or timeout: the pipe advances this cycle and
                    // a new request is not considered until back in RUN.
                    w_pc_we     = w_res_pc_we;
                    w_if_id_we  = w_res_if_id_we;
                    w_id_ex_we  = w_res_id_ex_we;
                    w_ex_mem_we = w_res_ex_mem_we;
                    w_if_id_fl  = w_res_if_id_fl;
                    w_id_ex_fl  = w_res_id_ex_fl;
                    w_timeout   = !mem_ready;
                    if (ex_halt) begin
                        w_next_state = S_HALT;
                        w_halt_entry = 1'b1;
                    end else begin
                        w_next_state = S_RUN;
                    end
                end else begin
                    w_wait_inc = 1'b1;
                end
            end

            S_HALT: begin
                w_next_state = S_HALT;
            end

            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // A cycle that holds the PC is a stall, except the cycle that enters HALT.
    assign w_stall = (r_state != S_HALT) && !w_pc_we && !w_halt_entry;

    // Reset forces bubbles into the reset-less pipeline registers.
    assign pc_write_en     = reset_n & w_pc_we;
    assign if_id_write_en  = reset_n & w_if_id_we;
    assign id_ex_write_en  = reset_n & w_id_ex_we;
    assign ex_mem_write_en = reset_n & w_ex_mem_we;
    assign if_id_flush     = ~reset_n | w_if_id_fl;
    assign id_ex_flush     = ~reset_n | w_id_ex_fl;

    assign halted      = r_halted;
    assign mem_error   = r_mem_error;
    assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Testbench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, a randomized phase, and a counter-saturation run, all checked
// every cycle against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned AW = 3;
    localparam int unsigned TO = 8;

    logic          clock;
    logic          reset_n;
    logic [AW-1:0] id_src_a, id_src_b, ex_dest;
    logic          id_use_a, id_use_b;
    logic          ex_memRead, ex_regWrite, ex_halt, ex_branch_taken, ex_jump;
    logic          mem_req, mem_ready;
    logic          pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en;
    logic          if_id_flush, id_ex_flush, halted, mem_error;
    logic [15:0]   stall_count;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.REG_ADDR_W(AW), .MEM_TIMEOUT(TO)) dut (
        .clock(clock), .reset_n(reset_n),
        .id_src_a(id_src_a), .id_src_b(id_src_b),
        .id_use_a(id_use_a), .id_use_b(id_use_b),
        .ex_dest(ex_dest), .ex_memRead(ex_memRead), .ex_regWrite(ex_regWrite),
        .ex_halt(ex_halt), .ex_branch_taken(ex_branch_taken), .ex_jump(ex_jump),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
        .id_ex_write_en(id_ex_write_en), .ex_mem_write_en(ex_mem_write_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .halted(halted), .mem_error(mem_error), .stall_count(stall_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_k: cycles spent waiting since the request cycle (1 on the first wait cycle).
    bit m_halted, m_waiting, m_err;
    int m_k, m_stalls;
    bit n_halted, n_waiting, n_err;
    int n_k, n_stalls;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_halted <= 0; m_waiting <= 0; m_err <= 0; m_k <= 0; m_stalls <= 0;
        end else begin
            m_halted <= n_halted; m_waiting <= n_waiting; m_err <= n_err;
            m_k <= n_k; m_stalls <= n_stalls;
        end
    end

    // Mid-cycle compare of all outputs, then compute the model's next state.
    always @(negedge clock) begin : cmp
        logic [3:0] e_en;
        logic [1:0] e_fl;
        bit lu, rd, stall;
        n_halted = m_halted; n_waiting = m_waiting; n_err = m_err;
        n_k = m_k; n_stalls = m_stalls;
        e_en = 4'h0; e_fl = 2'b00; stall = 0;
        lu = ex_memRead && ex_regWrite &&
             ((id_use_a && id_src_a == ex_dest) || (id_use_b && id_src_b == ex_dest));
        rd = ex_branch_taken || ex_jump;
        if (!reset_n) begin
            e_fl = 2'b11;
        end else if (m_halted) begin
            e_en = 4'h0;
        end else if (m_waiting && !mem_ready && m_k < int'(TO)) begin
            n_k = m_k + 1;
            stall = 1;
        end else begin
            if (m_waiting) begin
                n_waiting = 0;
                if (!mem_ready) n_err = 1;
            end
            if (ex_halt) begin
                e_en = 4'b0011; e_fl = 2'b11; n_halted = 1;
            end else if (!m_waiting && mem_req && !mem_ready) begin
                n_waiting = 1; n_k = 1; stall = 1;
            end else if (rd) begin
                e_en = 4'hF; e_fl = 2'b11;
            end else if (lu) begin
                e_en = 4'b0011; e_fl = 2'b01; stall = 1;
            end else begin
                e_en = 4'hF;
            end
        end
        if (stall && n_stalls < 65535) n_stalls = n_stalls + 1;

        check("model_enables",
              32'({pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en}), 32'(e_en));
        check("model_flushes", 32'({if_id_flush, id_ex_flush}), 32'(e_fl));
        check("model_halted", 32'(halted), 32'(m_halted));
        check("model_mem_error", 32'(mem_error), 32'(m_err));
        check("model_stall_count", 32'(stall_count), 32'(m_stalls));
    end

    // ---------------- stimulus ----------------
    task automatic set_idle();
        id_src_a = '0; id_src_b = '0; ex_dest = '0;
        id_use_a = 0; id_use_b = 0; ex_memRead = 0; ex_regWrite = 0;
        ex_halt = 0; ex_branch_taken = 0; ex_jump = 0; mem_req = 0; mem_ready = 0;
    endtask

    task automatic set_load_use();
        ex_memRead = 1; ex_regWrite = 1; ex_dest = 3'd3; id_use_a = 1; id_src_a = 3'd3;
    endtask

    task automatic nxt_cyc();
        @(posedge clock); #1;
    endtask

    task automatic at_neg();
        @(negedge clock); #1;
    endtask

    function automatic logic [31:0] en4();
        return 32'({pc_write_en, if_id_write_en, id_ex_write_en, ex_mem_write_en});
    endfunction

    function automatic logic [31:0] fl2();
        return 32'({if_id_flush, id_ex_flush});
    endfunction

    initial begin
        int rst_left;
        int ready_pct;
        reset_n = 0;
        set_idle();
        repeat (3) nxt_cyc();
        at_neg();
        check("reset_enables", en4(), 32'h0);
        check("reset_flushes", fl2(), 32'h3);
        check("reset_stall_count", 32'(stall_count), 32'd0);
        nxt_cyc(); reset_n = 1;
        at_neg();
        check("run_default_enables", en4(), 32'hF);
        check("run_default_flushes", fl2(), 32'h0);

        // Load-use: one bubble, count 0 -> 1.
        nxt_cyc(); set_load_use();
        at_neg();
        check("lu_enables", en4(), 32'h3);
        check("lu_flushes", fl2(), 32'h1);
        nxt_cyc(); set_idle();
        at_neg();
        check("lu_stall_count", 32'(stall_count), 32'd1);
        check("lu_released", 32'(pc_write_en), 32'd1);

        // Same stimulus without the source read: no stall.
        nxt_cyc(); set_load_use(); id_use_a = 0;
        at_neg();
        check("nouse_pc_we", 32'(pc_write_en), 32'd1);
        nxt_cyc(); set_idle();
        at_neg();
        check("nouse_stall_count", 32'(stall_count), 32'd1);

        // Load-use with a taken branch: branch wins.
        nxt_cyc(); set_load_use(); ex_branch_taken = 1;
        at_neg();
        check("lu_br_enables", en4(), 32'hF);
        check("lu_br_flushes", fl2(), 32'h3);
        nxt_cyc(); set_idle();
        at_neg();
        check("lu_br_stall_count", 32'(stall_count), 32'd1);

        // Memory wait: ready arrives after 4 cycles.
        nxt_cyc(); mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            at_neg();
            check("memwait_enables", en4(), 32'h0);
            nxt_cyc();
        end
        mem_ready = 1;
        at_neg();
        check("memwait_done_enables", en4(), 32'hF);
        nxt_cyc(); set_idle();
        at_neg();
        check("memwait_stall_count", 32'(stall_count), 32'd5);
        check("memwait_no_error", 32'(mem_error), 32'd0);

        // Reset asserted mid-MEMWAIT acts immediately.
        nxt_cyc(); mem_req = 1;
        nxt_cyc(); #1 reset_n = 0;
        #1;
        check("midwait_reset_enables", en4(), 32'h0);
        check("midwait_reset_flushes", fl2(), 32'h3);
        set_idle();
        repeat (3) nxt_cyc();
        reset_n = 1;
        at_neg();
        check("post_reset_stall_count", 32'(stall_count), 32'd0);
        check("post_reset_mem_error", 32'(mem_error), 32'd0);
        check("post_reset_enables", en4(), 32'hF);

        // Timeout: 8 stall cycles, 9th advances, error sticks.
        nxt_cyc(); mem_req = 1;
        for (int i = 0; i < 8; i++) begin
            at_neg();
            check("timeout_wait_enables", en4(), 32'h0);
            nxt_cyc();
        end
        at_neg();
        check("timeout_cycle_enables", en4(), 32'hF);
        check("timeout_cycle_no_error_yet", 32'(mem_error), 32'd0);
        nxt_cyc(); set_idle();
        at_neg();
        check("timeout_mem_error", 32'(mem_error), 32'd1);
        check("timeout_stall_count", 32'(stall_count), 32'd8);
        repeat (3) nxt_cyc();
        at_neg();
        check("mem_error_sticky", 32'(mem_error), 32'd1);

        // Halt: everything frozen, inputs ignored.
        nxt_cyc(); ex_halt = 1;
        at_neg();
        check("halt_entry_enables", en4(), 32'h3);
        check("halt_entry_flushes", fl2(), 32'h3);
        check("halt_entry_not_halted_yet", 32'(halted), 32'd0);
        nxt_cyc(); ex_halt = 0; ex_branch_taken = 1; mem_req = 1;
        for (int i = 0; i < 10; i++) begin
            at_neg();
            check("halted_flag", 32'(halted), 32'd1);
            check("halted_enables", en4(), 32'h0);
            check("halted_flushes", fl2(), 32'h0);
            check("halted_stall_frozen", 32'(stall_count), 32'd8);
            nxt_cyc();
        end
        reset_n = 0; set_idle();
        repeat (2) nxt_cyc();
        reset_n = 1;
        at_neg();
        check("halt_recovered", 32'(halted), 32'd0);
        check("halt_recovered_enables", en4(), 32'hF);

        // Randomized traffic, checked by the model every cycle.
        rst_left = 0;
        ready_pct = 50;
        for (int i = 0; i < 3000; i++) begin
            nxt_cyc();
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset_n = 1;
            end else if ($urandom_range(0, 59) == 0) begin
                reset_n = 0;
                rst_left = int'($urandom_range(1, 3));
            end
            if (i % 40 == 0) ready_pct = int'($urandom_range(3, 90));
            id_src_a        = AW'($urandom_range(0, 7));
            id_src_b        = AW'($urandom_range(0, 7));
            ex_dest         = AW'($urandom_range(0, 7));
            id_use_a        = ($urandom_range(0, 1) == 1);
            id_use_b        = ($urandom_range(0, 1) == 1);
            ex_memRead      = ($urandom_range(0, 2) == 0);
            ex_regWrite     = ($urandom_range(0, 1) == 1);
            ex_halt         = ($urandom_range(0, 149) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            ex_jump         = ($urandom_range(0, 15) == 0);
            mem_req         = ($urandom_range(0, 3) == 0);
            mem_ready       = (int'($urandom_range(0, 99)) < ready_pct);
        end

        // Saturation: a load-use held forever stalls every cycle.
        nxt_cyc(); reset_n = 0; set_idle();
        nxt_cyc(); reset_n = 1; set_load_use();
        repeat (65540) nxt_cyc();
        at_neg();
        check("stall_count_saturated", 32'(stall_count), 32'hFFFF);
        nxt_cyc();
        at_neg();
        check("stall_count_no_wrap", 32'(stall_count), 32'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
